// File: rtl/muldiv_hilo_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO pair. It runs one bit per
// cycle: shift-add for multiply, restoring for divide, then a sign-fix cycle.
module muldiv_hilo_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e          state_q, state_d;
  logic            done_q;
  logic            dz_flag_q;
  logic [DW-1:0]   hi_q, lo_q;

  logic [2*DW-1:0] work_q;
  logic [DW-1:0]   opb_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q;
  logic            dz_q;
  logic            neg_lo_q;
  logic            neg_hi_q;

  logic            idle;
  logic            accept_md;
  logic            accept_mt;
  logic            op_signed;
  logic            a_neg, b_neg;
  logic [DW:0]     mul_sum;
  logic [DW:0]     div_diff;
  logic [2*DW-1:0] work_step;
  logic [DW-1:0]   res_hi, res_lo;

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic is_signed);
    logic signed [DW-1:0] sv;
    sv = v;
    return (is_signed && (sv < 0)) ? -v : v;
  endfunction

  function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*DW-1:0] cond_neg_w(input logic [2*DW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign idle      = (state_q == S_IDLE);
  // flush wins over a same-cycle start, including the single-cycle moves
  assign accept_md = idle && start && !flush && !op[2];
  assign accept_mt = idle && start && !flush && (op == 3'd4 || op == 3'd5);
  assign op_signed = !op[0];
  assign a_neg     = op_signed && src_a[DW-1];
  assign b_neg     = op_signed && src_b[DW-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_md) state_d = S_CALC;
      S_CALC: begin
        if (flush)                       state_d = S_IDLE;
        else if (cnt_q == CW'(DW - 1))   state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // work_q holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum  = {1'b0, work_q[2*DW-1:DW]} + {1'b0, (work_q[0] ? opb_q : {DW{1'b0}})};
    div_diff = work_q[2*DW-1:DW-1] - {1'b0, opb_q};
    if (is_div_q) begin
      if (div_diff[DW]) work_step = {work_q[2*DW-2:0], 1'b0};
      else              work_step = {div_diff[DW-1:0], work_q[DW-2:0], 1'b1};
    end else begin
      work_step = {mul_sum, work_q[DW-1:1]};
    end
  end

  always_comb begin
    {res_hi, res_lo} = cond_neg_w(work_q, neg_lo_q);
    if (is_div_q) begin
      res_lo = dz_q ? {DW{1'b1}} : cond_neg(work_q[DW-1:0], neg_lo_q);
      res_hi = cond_neg(work_q[2*DW-1:DW], neg_hi_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept_md || accept_mt) dz_flag_q <= 1'b0;
      if (accept_mt) begin
        if (op[0]) lo_q <= src_a;
        else       hi_q <= src_a;
      end
      if (state_q == S_FIX && !flush) begin
        done_q    <= 1'b1;
        hi_q      <= res_hi;
        lo_q      <= res_lo;
        dz_flag_q <= is_div_q && dz_q;
      end
    end
  end

  // Datapath registers: loaded on accept, so they need no reset
  always_ff @(posedge clk) begin
    if (accept_md) begin
      work_q   <= {{DW{1'b0}}, magnitude(src_a, op_signed)};
      opb_q    <= magnitude(src_b, op_signed);
      cnt_q    <= '0;
      is_div_q <= op[1];
      dz_q     <= (src_b == '0);
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
    end else if (state_q == S_CALC) begin
      work_q <= work_step;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign busy     = !idle;
  assign done     = done_q;
  assign div_zero = dz_flag_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: arithmetic results, latency, handshake,
// flush and reset abort, with hand-computed expected values.
module tb_muldiv_hilo_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [2:0]    op;
  logic [DW-1:0] src_a, src_b;
  logic          busy, done, div_zero;
  logic [DW-1:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues an op, checks busy width / no early done / hi-lo hold, ends one step after the write edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] old_hi,
                        input logic [DW-1:0] old_lo, input logic poke);
    int bcnt;
    int dcnt;
    bcnt  = 0;
    dcnt  = 0;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    for (int i = 0; i <= DW; i++) begin
      if (busy) bcnt++;
      if (done) dcnt++;
      if (poke && i >= 4 && i < 8) begin
        start = 1'b1; op = 3'd4; src_a = 32'hDEAD_0000;
      end else begin
        start = 1'b0;
      end
      if (i < DW) tick();
    end
    chk({tag, " busy_cycles"}, bcnt, DW + 1);
    chk({tag, " early_done"},  dcnt, 0);
    chk({tag, " hi_hold"},     hi, old_hi);
    chk({tag, " lo_hold"},     lo, old_lo);
    tick();
    chk({tag, " done_pulse"},  done, 1);
    chk({tag, " busy_drop"},   busy, 0);
  endtask

  initial begin
    int dcnt;
    int bcnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst dz",   div_zero, 0);
    chk("rst hi",   hi, 0);
    chk("rst lo",   lo, 0);

    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 1'b0);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFF1);
    tick();
    chk("mult done_once", done, 0);

    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    chk("multu hi", hi, 32'hFFFF_FFFE);
    chk("multu lo", lo, 32'h0000_0001);

    // issued in the cycle done is high
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    chk("divu lo", lo, 32'd14);
    chk("divu hi", hi, 32'd2);
    tick();

    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'd14, 1'b0);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);
    chk("div dz", div_zero, 0);
    tick();

    run_op("div0", 3'd2, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    chk("div0 lo", lo, 32'hFFFF_FFFF);
    chk("div0 hi", hi, 32'h0000_1234);
    chk("div0 dz", div_zero, 1);
    tick();
    chk("div0 dz_sticky", div_zero, 1);

    start = 1'b1; op = 3'd5; src_a = 32'h55;
    tick();
    start = 1'b0;
    chk("mtlo lo",   lo, 32'h55);
    chk("mtlo hi",   hi, 32'h1234);
    chk("mtlo dz",   div_zero, 0);
    chk("mtlo busy", busy, 0);
    chk("mtlo done", done, 0);

    start = 1'b1; op = 3'd4; src_a = 32'hA5A5;
    tick();
    start = 1'b0;
    chk("mthi hi", hi, 32'hA5A5);

    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'hA5A5, 32'h55, 1'b1);
    chk("divovf lo", lo, 32'h8000_0000);
    chk("divovf hi", hi, 32'h0);
    tick();

    start = 1'b1; op = 3'd6; src_a = 32'h77;
    tick();
    start = 1'b0;
    chk("op6 hi",   hi, 32'h0);
    chk("op6 lo",   lo, 32'h8000_0000);
    chk("op6 busy", busy, 0);

    flush = 1'b1; start = 1'b1; op = 3'd4; src_a = 32'h99;
    tick();
    chk("flush_mthi hi", hi, 32'h0);
    op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick();
    chk("flush_mult busy", busy, 0);
    flush = 1'b0; start = 1'b0;
    tick();
    chk("flush_mult stays_idle", busy, 0);

    start = 1'b1; op = 3'd4; src_a = 32'h11;
    tick();
    op = 3'd5; src_a = 32'h22;
    tick();
    start = 1'b0;

    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("flush pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush done", done, 0);
    chk("flush hi",   hi, 32'h11);
    chk("flush lo",   lo, 32'h22);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("flush no_done", dcnt, 0);
    chk("flush no_busy", bcnt, 0);
    chk("flush hi_late", hi, 32'h11);

    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort hi",   hi, 32'h0);
    chk("abort lo",   lo, 32'h0);

    run_op("post_rst", 3'd1, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0);
    chk("post_rst hi", hi, 32'h0);
    chk("post_rst lo", lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
